icache_dm: RTL and testbench
============================

ICACHE_DM -- requirements
Module: icache_dm

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, meaning byte-address width of PCF and mem_addr.
REQ-002 SHALL have parameter LINES, default 16, meaning number of direct-mapped lines (power of two, 4 words each).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port PCF  input  ADDRESS_WIDTH  fetch address from the fetch stage.
REQ-006 SHALL have port InstrF  output  32  instruction returned to the fetch stage.
REQ-007 SHALL have port StallF  output  1  high while PCF misses or a refill is in progress; fetch stage holds PCF.
REQ-008 SHALL have port inval  input  1  invalidate all lines (fence.i / pipeline flush).
REQ-009 SHALL have port mem_req  output  1  refill request to backing instruction memory.
REQ-010 SHALL have port mem_addr  output  ADDRESS_WIDTH  line-aligned refill address.
REQ-011 SHALL have port mem_rdata  input  32  refill data beat.
REQ-012 SHALL have port mem_rvalid  input  1  mem_rdata valid this cycle.
REQ-013 SHALL have port miss_count  output  32  number of refills started since reset.

Function
REQ-014 Address split SHALL be: offset = PCF[3:2], index = PCF[3+log2(LINES):4], tag = remaining upper bits; PCF[1:0] ignored.
REQ-015 Per line SHALL store valid bit, tag, 4x32-bit data words.
REQ-016 FSM SHALL have states IDLE and REFILL.
REQ-017 IDLE, hit (valid and tag match): InstrF = stored word combinationally same cycle, StallF = 0, zero-cycle latency.
REQ-018 IDLE, miss: StallF = 1 same cycle; next edge -> REFILL, latch refill tag/index, miss_count += 1.
REQ-019 REFILL: mem_req = 1, mem_addr = {latched tag, index, 4'b0000}, both constant until final beat.
REQ-020 REFILL: each mem_rvalid beat SHALL write word at beat counter (0,1,2,3 in order), counter increments.
REQ-021 On 4th beat: write tag, set valid, return to IDLE next cycle; mem_req deasserts the cycle after 4th beat.
REQ-022 First hit after refill SHALL occur in the IDLE cycle following the 4th beat (refill penalty = 1 + memory latency + 4 beats + 1 minimum).
REQ-023 mem_rvalid in IDLE SHALL be ignored.
REQ-024 While StallF = 1, InstrF SHALL be 32'h00000013 (NOP).
REQ-025 inval in IDLE: all valid bits cleared next edge; hit lookup in the same cycle uses pre-clear state.
REQ-026 inval during REFILL: all valid bits cleared; refill beats still consumed to completion, but the refilled line SHALL NOT be marked valid; return to IDLE (re-miss follows).
REQ-027 PCF change during REFILL SHALL be ignored; lookup resumes with current PCF in IDLE.
REQ-028 miss_count SHALL wrap from 32'hFFFFFFFF to 0.

Reset
REQ-029 rst SHALL, on the next edge, force IDLE, clear all valid bits, beat counter = 0, miss_count = 0, mem_req = 0.
REQ-030 rst mid-REFILL SHALL abort: mem_req = 0 the cycle after reset, pending beats ignored, no line validated.
REQ-031 During rst high, StallF follows IDLE lookup (all miss after first reset edge), InstrF = NOP.

Verification
REQ-032 Cold fetch: rst, PCF=0x00000000, memory returns 0xA,0xB,0xC,0xD after 2 cycles -> mem_addr=0x0, miss_count=1, then PCF=0x0/0x4/0x8/0xC hit with 0xA/0xB/0xC/0xD, StallF=0.
REQ-033 Conflict: after line 0x000 loaded, PCF=0x100 (same index, LINES=16) -> miss, refill at 0x100, then PCF=0x000 misses again, miss_count=3.
REQ-034 inval in IDLE with line 0x0 valid -> next cycle PCF=0x0 StallF=1, mem_req=1 following edge.
REQ-035 inval on 2nd refill beat -> remaining beats consumed, IDLE, PCF retried misses, miss_count increments again.
REQ-036 rst asserted on 3rd refill beat -> mem_req=0 next cycle, miss_count=0, late mem_rvalid beats produce no hit.
REQ-037 Stray mem_rvalid=1 with mem_rdata=0xDEADBEEF in IDLE -> no array change, hits unchanged.

Source files
------------

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: 4-word lines, zero-latency hits, 4-beat in-order refill.
// Single clock, synchronous active-high reset.
module icache_dm #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned LINES         = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] PCF,
  output logic [31:0]              InstrF,
  output logic                     StallF,
  input  logic                     inval,
  output logic                     mem_req,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  input  logic [31:0]              mem_rdata,
  input  logic                     mem_rvalid,
  output logic [31:0]              miss_count
);

  localparam int unsigned IdxW = $clog2(LINES);
  localparam int unsigned TagW = ADDRESS_WIDTH - 4 - IdxW;
  localparam logic [31:0] Nop  = 32'h0000_0013;

  typedef enum logic [0:0] {StIdle, StRefill} state_e;

  state_e            state_q;
  logic [LINES-1:0]  valid_q;
  logic [TagW-1:0]   tag_q [LINES];
  logic [31:0]       data_q [LINES][4];
  logic [1:0]        beat_q;
  logic [TagW-1:0]   refill_tag_q;
  logic [IdxW-1:0]   refill_idx_q;
  logic              inval_pend_q;
  logic              mem_req_q;
  logic [31:0]       miss_count_q;

  logic [1:0]        pc_off;
  logic [IdxW-1:0]   pc_idx;
  logic [TagW-1:0]   pc_tag;
  logic              hit;
  logic              unused_pcf;

  assign pc_off     = PCF[3:2];
  assign pc_idx     = PCF[IdxW+3:4];
  assign pc_tag     = PCF[ADDRESS_WIDTH-1:IdxW+4];
  assign unused_pcf = ^PCF[1:0];

  assign hit = (state_q == StIdle) && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);

  assign StallF     = ~hit;
  // Reset forces NOP even if a still-valid line would hit before the reset edge.
  assign InstrF     = (hit && !rst) ? data_q[pc_idx][pc_off] : Nop;
  assign mem_req    = mem_req_q;
  assign mem_addr   = {refill_tag_q, refill_idx_q, 4'b0000};
  assign miss_count = miss_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      valid_q      <= '0;
      beat_q       <= '0;
      refill_tag_q <= '0;
      refill_idx_q <= '0;
      inval_pend_q <= 1'b0;
      mem_req_q    <= 1'b0;
      miss_count_q <= '0;
    end else begin
      if (inval) valid_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (!hit) begin
            state_q      <= StRefill;
            refill_tag_q <= pc_tag;
            refill_idx_q <= pc_idx;
            beat_q       <= '0;
            inval_pend_q <= 1'b0;
            mem_req_q    <= 1'b1;
            miss_count_q <= miss_count_q + 32'd1;
          end
        end
        StRefill: begin
          if (inval) inval_pend_q <= 1'b1;
          if (mem_rvalid) begin
            beat_q <= beat_q + 2'd1;
            if (beat_q == 2'd3) begin
              // An invalidate seen at any point in the refill leaves the line invalid.
              tag_q[refill_idx_q]   <= refill_tag_q;
              valid_q[refill_idx_q] <= !(inval || inval_pend_q);
              state_q               <= StIdle;
              mem_req_q             <= 1'b0;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && (state_q == StRefill) && mem_rvalid) begin
      data_q[refill_idx_q][beat_q] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: cold fetch, conflict, invalidate, reset abort, stray beats.
module tb_icache_dm;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] PCF;
  logic [31:0] InstrF;
  logic        StallF;
  logic        inval;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic [31:0] miss_count;

  int checks = 0;
  int errors = 0;

  icache_dm #(
    .ADDRESS_WIDTH(32),
    .LINES        (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .PCF       (PCF),
    .InstrF    (InstrF),
    .StallF    (StallF),
    .inval     (inval),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_rvalid(mem_rvalid),
    .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called in a REFILL cycle: idle waits, then four beats base..base+3; returns in IDLE.
  task automatic beats(input logic [31:0] base, input int waits);
    for (int i = 0; i < waits; i++) tick();
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = base + i;
      tick();
    end
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    #1;
  endtask

  initial begin
    rst = 1'b1; PCF = '0; inval = 1'b0; mem_rdata = '0; mem_rvalid = 1'b0;
    tick(); tick(); #1;
    chk("rst_stall", 32'(StallF), 32'd1);
    chk("rst_instr", InstrF, NOP);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_mc", miss_count, 32'd0);

    // Cold fetch
    rst = 1'b0; #1;
    chk("cold_stall", 32'(StallF), 32'd1);
    chk("cold_req_idle", 32'(mem_req), 32'd0);
    tick(); #1;
    chk("cold_req", 32'(mem_req), 32'd1);
    chk("cold_addr", mem_addr, 32'h0);
    chk("cold_mc", miss_count, 32'd1);
    beats(32'hA, 2);
    chk("cold_req_done", 32'(mem_req), 32'd0);
    for (int i = 0; i < 4; i++) begin
      PCF = 32'(i * 4); #1;
      chk("cold_hit_stall", 32'(StallF), 32'd0);
      chk("cold_hit_instr", InstrF, 32'hA + 32'(i));
      tick();
    end

    // Conflict on index 0
    PCF = 32'h100; #1;
    chk("conf_stall", 32'(StallF), 32'd1);
    tick(); #1;
    chk("conf_addr", mem_addr, 32'h100);
    chk("conf_mc", miss_count, 32'd2);
    beats(32'h100, 1);
    PCF = 32'h104; #1;
    chk("conf_hit", InstrF, 32'h101);
    PCF = 32'h0; #1;
    chk("conf_remiss", 32'(StallF), 32'd1);
    tick(); #1;
    chk("conf_mc3", miss_count, 32'd3);
    chk("conf_addr0", mem_addr, 32'h0);
    beats(32'hA, 0);
    PCF = 32'hC; #1;
    chk("conf_reload", InstrF, 32'hD);

    // Stray beats in IDLE
    PCF = 32'h0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick(); tick();
    mem_rvalid = 1'b0; mem_rdata = '0; #1;
    chk("stray_instr", InstrF, 32'hA);
    chk("stray_stall", 32'(StallF), 32'd0);
    chk("stray_req", 32'(mem_req), 32'd0);
    chk("stray_mc", miss_count, 32'd3);
    PCF = 32'h4; #1;
    chk("stray_instr4", InstrF, 32'hB);
    tick();

    // Invalidate in IDLE: same-cycle lookup still hits
    PCF = 32'h0; inval = 1'b1; #1;
    chk("inv_prehit", InstrF, 32'hA);
    tick();
    inval = 1'b0; #1;
    chk("inv_stall", 32'(StallF), 32'd1);
    chk("inv_req_idle", 32'(mem_req), 32'd0);
    tick(); #1;
    chk("inv_req", 32'(mem_req), 32'd1);
    chk("inv_mc", miss_count, 32'd4);
    // PCF moves during refill: address and stall unaffected
    PCF = 32'h30; #1;
    chk("pcmove_addr", mem_addr, 32'h0);
    chk("pcmove_stall", 32'(StallF), 32'd1);
    chk("pcmove_instr", InstrF, NOP);
    beats(32'hA, 1);
    chk("pcmove_miss30", 32'(StallF), 32'd1);
    PCF = 32'h0; #1;
    chk("pcmove_hit0", InstrF, 32'hA);
    tick();

    // Invalidate on the second refill beat
    PCF = 32'h40; #1;
    chk("rinv_stall", 32'(StallF), 32'd1);
    tick(); #1;
    chk("rinv_mc", miss_count, 32'd5);
    chk("rinv_addr", mem_addr, 32'h40);
    mem_rvalid = 1'b1; mem_rdata = 32'h40; tick();
    mem_rdata = 32'h41; inval = 1'b1; tick();
    inval = 1'b0; mem_rdata = 32'h42; tick();
    mem_rdata = 32'h43; tick();
    mem_rvalid = 1'b0; mem_rdata = '0; #1;
    chk("rinv_req_done", 32'(mem_req), 32'd0);
    chk("rinv_notvalid", 32'(StallF), 32'd1);
    PCF = 32'h0; #1;
    chk("rinv_line0_clr", 32'(StallF), 32'd1);
    PCF = 32'h40;
    tick(); #1;
    chk("rinv_retry_mc", miss_count, 32'd6);
    chk("rinv_retry_req", 32'(mem_req), 32'd1);
    beats(32'h50, 0);
    PCF = 32'h44; #1;
    chk("rinv_retry_hit", InstrF, 32'h51);
    chk("rinv_retry_stall", 32'(StallF), 32'd0);
    tick();

    // Reset on the third refill beat
    PCF = 32'h80; #1;
    tick(); #1;
    chk("rrst_mc7", miss_count, 32'd7);
    mem_rvalid = 1'b1; mem_rdata = 32'h80; tick();
    mem_rdata = 32'h81; tick();
    mem_rdata = 32'h82; rst = 1'b1; tick(); #1;
    chk("rrst_req", 32'(mem_req), 32'd0);
    chk("rrst_mc", miss_count, 32'd0);
    chk("rrst_stall", 32'(StallF), 32'd1);
    chk("rrst_instr", InstrF, NOP);
    mem_rdata = 32'h83; tick();
    mem_rvalid = 1'b0; mem_rdata = '0; rst = 1'b0; #1;
    chk("rrst_late_stall", 32'(StallF), 32'd1);
    chk("rrst_late_req", 32'(mem_req), 32'd0);
    PCF = 32'h40; #1;
    chk("rrst_all_invalid", 32'(StallF), 32'd1);
    tick(); #1;
    chk("rrst_new_req", 32'(mem_req), 32'd1);
    chk("rrst_new_mc", miss_count, 32'd1);
    chk("rrst_new_addr", mem_addr, 32'h40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
